// File: rtl/mips_cache_pkg.sv
// Shared types and constants for the data-cache write buffer.
package mips_cache_pkg;

   // Drain FSM: idle, or one Avalon write in flight.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } wb_state_t;

   localparam int BYTE_W = 8;

endpackage

// File: rtl/mips_cache_wb_match.sv
// DEPTH-way word-address comparator. Reports whether any entry whose
// valid bit is set holds the probed word address. Used for the cache
// coherency lookup and for the store-merge check.
module mips_cache_wb_match #(
   parameter int WORD_W = 30,
   parameter int DEPTH  = 8
) (
   input  logic [DEPTH*WORD_W-1:0] entry_word_i,
   input  logic [DEPTH-1:0]        valid_i,
   input  logic [WORD_W-1:0]       probe_i,
   output logic                    hit_o
);

   // OR-reduce the per-entry matches over the valid entries.
   always_comb begin
      hit_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_i[i] && (entry_word_i[i*WORD_W +: WORD_W] == probe_i)) begin
            hit_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mips_cache_write_fifo.sv
// Posted-write buffer between the data cache and the Avalon-MM write port.
// Stores are pushed with a valid/ready handshake and drained in push order,
// one Avalon write per entry. drain_en gates only the start of new writes.
// Optional feature macro: WB_MERGE_EN (merge a store into the youngest
// entry when the word addresses match and that entry is not on the bus).
//
// Handshake: a store is taken on every rising edge where wb_valid and
// wb_ready are both high; wb_valid is a level, not an edge, and the cache
// must hold address/data/byteenable stable while wb_valid is high.
module mips_cache_write_fifo
   import mips_cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_valid,
   output logic                     wb_ready,
   input  logic [ADDR_W-1:0]        wb_addr,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic [DATA_W/BYTE_W-1:0] wb_byteenable,
   input  logic [ADDR_W-1:0]        lookup_addr,
   output logic                     lookup_hit,
   input  logic                     drain_en,
   input  logic                     avm_waitrequest,
   output logic [ADDR_W-1:0]        avm_address,
   output logic [DATA_W-1:0]        avm_writedata,
   output logic [DATA_W/BYTE_W-1:0] avm_byteenable,
   output logic                     avm_write,
   output logic [DEPTH_LOG2:0]      count,
   output logic                     full,
   output logic                     empty,
   output logic                     state_out
);

   localparam int BE_W   = DATA_W / BYTE_W;
   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int PTR_W  = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
   localparam int CNT_W  = DEPTH_LOG2 + 1;
   localparam int WORD_W = ADDR_W - 2;

   // Entry storage
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [BE_W-1:0]   be_q   [DEPTH];
   logic [DEPTH-1:0]  valid_q;

   logic [PTR_W-1:0]  head_q, tail_q, head_next;
   logic [CNT_W-1:0]  count_q, count_d;

   wb_state_t         state_q, state_d;
   logic              avm_write_q, avm_write_d;
   logic [ADDR_W-1:0] avm_addr_q, avm_addr_d;
   logic [DATA_W-1:0] avm_data_q, avm_data_d;
   logic [BE_W-1:0]   avm_be_q, avm_be_d;

   logic              push, pop, merge, load;
   logic [PTR_W-1:0]  load_idx;
   logic [DEPTH*WORD_W-1:0] word_flat;
   logic              unused_lookup_lsb;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign head_next = ptr_inc(head_q);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign state_out = logic'(state_q);

   assign avm_write      = avm_write_q;
   assign avm_address    = avm_addr_q;
   assign avm_writedata  = avm_data_q;
   assign avm_byteenable = avm_be_q;

   // Only the word address takes part in comparisons.
   assign unused_lookup_lsb = ^lookup_addr[1:0];

   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      assign word_flat[g*WORD_W +: WORD_W] = addr_q[g][ADDR_W-1:2];
   end

   // Coherency probe: the in-flight head stays valid until accepted.
   mips_cache_wb_match #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_lookup (
      .entry_word_i (word_flat),
      .valid_i      (valid_q),
      .probe_i      (lookup_addr[ADDR_W-1:2]),
      .hit_o        (lookup_hit)
   );

`ifdef WB_MERGE_EN
   logic [PTR_W-1:0] tail_prev;
   logic [DEPTH-1:0] merge_mask;
   logic             merge_hit;
   logic             merge_blocked;

   assign tail_prev = (tail_q == '0) ? PTR_W'(DEPTH - 1) : tail_q - PTR_W'(1);

   // The youngest entry is a merge target only if it is not on the bus now
   // and is not being loaded onto the bus at this edge.
   always_comb begin
      merge_blocked = ((state_q == S_BUSY) && (tail_prev == head_q)) ||
                      (load && (tail_prev == load_idx));
      merge_mask = '0;
      merge_mask[tail_prev] = valid_q[tail_prev] && !merge_blocked;
   end

   mips_cache_wb_match #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_merge (
      .entry_word_i (word_flat),
      .valid_i      (merge_mask),
      .probe_i      (wb_addr[ADDR_W-1:2]),
      .hit_o        (merge_hit)
   );

   assign merge    = wb_valid && merge_hit;
   assign wb_ready = !full || merge;
`else
   assign merge    = 1'b0;
   assign wb_ready = !full;
`endif

   assign push = wb_valid && wb_ready && !merge;
   assign pop  = (state_q == S_BUSY) && !avm_waitrequest;

   // Drain FSM next state and registered Avalon output values.
   always_comb begin
      state_d     = state_q;
      avm_write_d = avm_write_q;
      avm_addr_d  = avm_addr_q;
      avm_data_d  = avm_data_q;
      avm_be_d    = avm_be_q;
      load        = 1'b0;
      load_idx    = head_q;
      case (state_q)
         S_IDLE: begin
            if (!empty && drain_en) begin
               load        = 1'b1;
               avm_write_d = 1'b1;
               state_d     = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!avm_waitrequest) begin
               if ((count_q > CNT_W'(1)) && drain_en) begin
                  load     = 1'b1;
                  load_idx = head_next;
               end else begin
                  avm_write_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (load) begin
         avm_addr_d = addr_q[load_idx];
         avm_data_d = data_q[load_idx];
         avm_be_d   = be_q[load_idx];
      end
   end

   // Occupancy follows push/pop; a simultaneous pair leaves it unchanged.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers, valid bits, FSM state and Avalon outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         valid_q     <= '0;
         state_q     <= S_IDLE;
         avm_write_q <= 1'b0;
         avm_addr_q  <= '0;
         avm_data_q  <= '0;
         avm_be_q    <= '0;
      end else begin
         count_q     <= count_d;
         state_q     <= state_d;
         avm_write_q <= avm_write_d;
         avm_addr_q  <= avm_addr_d;
         avm_data_q  <= avm_data_d;
         avm_be_q    <= avm_be_d;
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_next;
         end
         if (push) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= ptr_inc(tail_q);
         end
      end
   end

   // Entry payload: new allocation at tail, or lane merge into the youngest.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= wb_addr;
         data_q[tail_q] <= wb_data;
         be_q[tail_q]   <= wb_byteenable;
      end
`ifdef WB_MERGE_EN
      else if (merge) begin
         for (int b = 0; b < BE_W; b++) begin
            if (wb_byteenable[b]) begin
               data_q[tail_prev][b*BYTE_W +: BYTE_W] <= wb_data[b*BYTE_W +: BYTE_W];
            end
         end
         be_q[tail_prev] <= be_q[tail_prev] | wb_byteenable;
      end
`endif
   end

endmodule

// File: tb/tb_mips_cache_write_fifo.sv
// Self-checking bench for mips_cache_write_fifo (default parameters).
// Honours WB_MERGE_EN for the merge scenario.
module tb_mips_cache_write_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_addr;
   logic [31:0] wb_data;
   logic [3:0]  wb_byteenable;
   logic [31:0] lookup_addr;
   logic        lookup_hit;
   logic        drain_en;
   logic        avm_waitrequest;
   logic [31:0] avm_address;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_write;
   logic [3:0]  count;
   logic        full;
   logic        empty;
   logic        state_out;

   int total = 0;
   int bad   = 0;

   // Expected Avalon writes in order: {address, data, byteenable}
   logic [67:0] exp_q[$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] probe;
      logic        exp_hit;
   } vec_t;

   vec_t vecs[4];

   mips_cache_write_fifo dut (
      .clk             (clk),
      .rst             (rst),
      .wb_valid        (wb_valid),
      .wb_ready        (wb_ready),
      .wb_addr         (wb_addr),
      .wb_data         (wb_data),
      .wb_byteenable   (wb_byteenable),
      .lookup_addr     (lookup_addr),
      .lookup_hit      (lookup_hit),
      .drain_en        (drain_en),
      .avm_waitrequest (avm_waitrequest),
      .avm_address     (avm_address),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_write       (avm_write),
      .count           (count),
      .full            (full),
      .empty           (empty),
      .state_out       (state_out)
   );

   // Clock
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [67:0] bus();
      return {avm_address, avm_writedata, avm_byteenable};
   endfunction

   // Present one store for one edge (no scoreboard entry).
   task automatic drive_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      wb_addr       = a;
      wb_data       = d;
      wb_byteenable = be;
      wb_valid      = 1'b1;
      tick();
      wb_valid      = 1'b0;
   endtask

   // Present one store that must be accepted, and expect it on the bus.
   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      wb_addr       = a;
      wb_data       = d;
      wb_byteenable = be;
      wb_valid      = 1'b1;
      #0;
      chk("push_ready", wb_ready, 1);
      exp_q.push_back({a, d, be});
      tick();
      wb_valid      = 1'b0;
   endtask

   // Drain with no stalls, comparing every bus write with the scoreboard.
   task automatic drain_check(input string name, output int nwr, output int span);
      int first;
      int last;
      bit done;
      nwr   = 0;
      first = -1;
      last  = -1;
      done  = 0;
      drain_en        = 1'b1;
      avm_waitrequest = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (avm_write) begin
            if (exp_q.size() == 0) begin
               chk({name, "_extra"}, 1, 0);
            end else begin
               chk(name, bus(), exp_q.pop_front());
            end
            nwr++;
            if (first < 0) first = c;
            last = c;
         end
         if (exp_q.size() == 0 && !avm_write && empty) begin
            done = 1;
            break;
         end
         tick();
      end
      chk({name, "_timeout"}, done, 1);
      chk({name, "_left"}, exp_q.size(), 0);
      span = (first < 0) ? 0 : last - first + 1;
   endtask

   initial begin
      int nwr;
      int span;

      vecs[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0000_0100, 1'b1};
      vecs[1] = '{32'h0000_0104, 32'h1234_5678, 4'h3, 32'h0000_0107, 1'b1};
      vecs[2] = '{32'h0000_01FC, 32'hA5A5_A5A5, 4'h8, 32'h0000_0200, 1'b0};
      vecs[3] = '{32'hFFFF_FFF0, 32'h0000_0000, 4'h0, 32'h7FFF_FFF0, 1'b0};

      // Reset
      rst             = 1'b1;
      wb_valid        = 1'b0;
      wb_addr         = '0;
      wb_data         = '0;
      wb_byteenable   = '0;
      lookup_addr     = '0;
      drain_en        = 1'b0;
      avm_waitrequest = 1'b0;
      tick();
      tick();
      chk("rst_avm_write", avm_write, 0);
      chk("rst_bus", bus(), 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ready", wb_ready, 1);
      chk("rst_hit", lookup_hit, 0);
      chk("rst_count", count, 0);
      chk("rst_state", state_out, 0);
      rst = 1'b0;
      tick();

      // Single-store latency, table driven
      for (int i = 0; i < 4; i++) begin
         drain_en        = 1'b1;
         avm_waitrequest = 1'b0;
         lookup_addr     = vecs[i].probe;
         drive_push(vecs[i].addr, vecs[i].data, vecs[i].be);
         chk("v_count1", count, 1);
         chk("v_write_e0", avm_write, 0);
         chk("v_hit", lookup_hit, vecs[i].exp_hit);
         tick();
         chk("v_write_e1", avm_write, 1);
         chk("v_bus", bus(), {vecs[i].addr, vecs[i].data, vecs[i].be});
         tick();
         chk("v_write_e2", avm_write, 0);
         chk("v_count0", count, 0);
         chk("v_empty", empty, 1);
         chk("v_hit_after", lookup_hit, 0);
      end

      // Fill to full with drain disabled, then burst drain
      drain_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push(32'h1000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'(i + 1));
      end
      chk("full_flag", full, 1);
      chk("full_ready", wb_ready, 0);
      chk("full_count", count, 8);
      drive_push(32'h2000, 32'h0BAD_0BAD, 4'hF);
      chk("full_blocked_count", count, 8);
      drain_check("burst", nwr, span);
      chk("burst_nwr", nwr, 8);
      chk("burst_span", span, 8);
      chk("burst_empty", empty, 1);

      // Full buffer: pop with a push pending at the same edge
      drain_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push(32'h1000 + 32'(i * 4), 32'h7700_0000 + 32'(i), 4'hF);
      end
      wb_addr         = 32'h3000;
      wb_data         = 32'h3333_3333;
      wb_byteenable   = 4'hF;
      wb_valid        = 1'b1;
      drain_en        = 1'b1;
      avm_waitrequest = 1'b1;
      tick();
      chk("fullpop_write", avm_write, 1);
      chk("fullpop_ready", wb_ready, 0);
      chk("fullpop_bus", bus(), exp_q.pop_front());
      avm_waitrequest = 1'b0;
      tick();
      wb_valid = 1'b0;
      chk("fullpop_count7", count, 7);
      chk("fullpop_ready_after", wb_ready, 1);
      drain_check("fullpop", nwr, span);

      // Push and pop at the same edge with count 4
      drain_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push(32'h4000 + 32'(i * 4), 32'h4400_0000 + 32'(i), 4'hF);
      end
      drain_en = 1'b1;
      tick();
      chk("pp_count_load", count, 4);
      chk("pp_write", avm_write, 1);
      chk("pp_bus", bus(), exp_q.pop_front());
      push(32'h5000, 32'h5555_5555, 4'h6);
      chk("pp_count_same", count, 4);
      drain_check("pp", nwr, span);

      // Stall for three cycles, drain_en dropped mid-transfer
      drain_en        = 1'b1;
      avm_waitrequest = 1'b1;
      push(32'h400, 32'h0400_0400, 4'hF);
      push(32'h404, 32'h0404_0404, 4'hC);
      drain_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("stall_write", avm_write, 1);
         chk("stall_bus", bus(), exp_q[0]);
         chk("stall_count", count, 2);
         tick();
      end
      avm_waitrequest = 1'b0;
      chk("stall_bus_release", bus(), exp_q.pop_front());
      tick();
      chk("stall_idle_write", avm_write, 0);
      chk("stall_idle_state", state_out, 0);
      chk("stall_idle_count", count, 1);
      tick();
      chk("stall_hold_write", avm_write, 0);
      drain_check("stall", nwr, span);

      // Lookup hit on word address
      drain_en = 1'b0;
      push(32'h200, 32'h0000_0055, 4'hF);
      lookup_addr = 32'h202;
      #1;
      chk("lk_202", lookup_hit, 1);
      lookup_addr = 32'h204;
      #1;
      chk("lk_204", lookup_hit, 0);
      lookup_addr = 32'h500;
      wb_addr       = 32'h500;
      wb_data       = 32'h0000_0500;
      wb_byteenable = 4'hF;
      wb_valid      = 1'b1;
      #1;
      chk("lk_same_cycle", lookup_hit, 0);
      exp_q.push_back({32'h500, 32'h0000_0500, 4'hF});
      tick();
      wb_valid = 1'b0;
      chk("lk_next_cycle", lookup_hit, 1);
      drain_check("lk", nwr, span);
      lookup_addr = 32'h202;
      #1;
      chk("lk_after_drain", lookup_hit, 0);

      // Same-word stores: merged or separate depending on build
      drain_en = 1'b0;
      drive_push(32'h300, 32'h0000_AAAA, 4'h3);
      drive_push(32'h300, 32'hBBBB_0000, 4'hC);
`ifdef WB_MERGE_EN
      chk("merge_count", count, 1);
      exp_q.push_back({32'h300, 32'hBBBB_AAAA, 4'hF});
`else
      chk("merge_count", count, 2);
      exp_q.push_back({32'h300, 32'h0000_AAAA, 4'h3});
      exp_q.push_back({32'h300, 32'hBBBB_0000, 4'hC});
`endif
      drain_check("merge", nwr, span);

      // Reset in the middle of a transfer
      drain_en        = 1'b1;
      avm_waitrequest = 1'b1;
      push(32'h600, 32'h0600_0600, 4'hF);
      push(32'h604, 32'h0604_0604, 4'hF);
      chk("mid_write", avm_write, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_write", avm_write, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_ready", wb_ready, 1);
      chk("mid_rst_state", state_out, 0);
      exp_q.delete();
      tick();
      rst             = 1'b0;
      avm_waitrequest = 1'b0;
      tick();
      tick();
      chk("post_rst_write", avm_write, 0);
      chk("post_rst_empty", empty, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
